// File: rtl/pwm_multi_gen_if.sv
// pwm_multi_gen_if: control/config and output bundle of the multi-channel PWM generator.
// Latency: none; this is wiring only. The controller drives en/cfg_*, and the generator drives pwm/period_tick/cfg_pending.
// Backpressure: none; cfg_load is a fire-and-forget strobe.
interface pwm_multi_gen_if #(
    parameter int CH = 4,
    parameter int CW = 8,
    parameter int PW = 6
);
    logic              en;
    logic              cfg_load;
    logic [PW-1:0]     cfg_presc;
    logic [CW-1:0]     cfg_period;
    logic [CH*CW-1:0]  cfg_duty;
    logic [CH-1:0]     pwm;
    logic              period_tick;
    logic              cfg_pending;

    modport master (
        output en, cfg_load, cfg_presc, cfg_period, cfg_duty,
        input  pwm, period_tick, cfg_pending
    );

    modport slave (
        input  en, cfg_load, cfg_presc, cfg_period, cfg_duty,
        output pwm, period_tick, cfg_pending
    );
endinterface

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: prescaled shared period counter driving CH duty comparators.
//   Period, prescale and duty are double-buffered and change only at a period boundary.
// Latency: pwm is registered 1 cycle after the cnt value it compares. period_tick is combinational from the registers.
// Backpressure: none. A load while running parks in the shadow set, and the last load before the boundary wins.
// Ports: clk_i, rst_ni (async, active low); bus.slave carries en, cfg_load, cfg_presc,
//        cfg_period, cfg_duty (in) and pwm, period_tick, cfg_pending (out).
module pwm_multi_gen #(
    parameter int CH         = 4,
    parameter int CW         = 8,
    parameter int PW         = 6,
    parameter int PRESC_RST  = 39,
    parameter int PERIOD_RST = 0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    pwm_multi_gen_if.slave bus
);
    localparam logic [PW-1:0] PRESC_INIT  = PW'(PRESC_RST);
    localparam logic [CW-1:0] PERIOD_INIT = CW'(PERIOD_RST);

    typedef logic [CH-1:0][CW-1:0] duty_t;

    // Active set (drives the outputs now) and shadow set (waits for a boundary)
    logic [PW-1:0] presc_a_q, presc_a_d, presc_s_q, presc_s_d;
    logic [CW-1:0] period_a_q, period_a_d, period_s_q, period_s_d;
    duty_t         duty_a_q, duty_a_d, duty_s_q, duty_s_d;

    logic [PW-1:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CH-1:0] pwm_q, pwm_d;
    logic          pend_q, pend_d;

    logic          step;
    logic          tick;

    assign step = bus.en && (pc_q == presc_a_q);
    assign tick = step && (cnt_q == period_a_q);

    // Keep the tick quiet while reset is held, even if the reset presc happens to match pc.
    assign bus.period_tick = tick && rst_ni;
    assign bus.pwm         = pwm_q;
    assign bus.cfg_pending = pend_q;

    always_comb begin
        presc_a_d  = presc_a_q;
        period_a_d = period_a_q;
        duty_a_d   = duty_a_q;
        presc_s_d  = presc_s_q;
        period_s_d = period_s_q;
        duty_s_d   = duty_s_q;
        pend_d     = pend_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        pwm_d      = '0;

        // Prescaler and period counter
        if (!bus.en) begin
            pc_d  = '0;
            cnt_d = '0;
        end else if (step) begin
            pc_d  = '0;
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end else begin
            pc_d  = pc_q + PW'(1);
        end

        // Configuration. A direct write is used when idle or exactly at the boundary.
        // Otherwise the write parks in the shadow until the next wrap.
        if (bus.cfg_load && !bus.en) begin
            presc_a_d  = bus.cfg_presc;
            period_a_d = bus.cfg_period;
            duty_a_d   = duty_t'(bus.cfg_duty);
        end else if (bus.cfg_load && tick) begin
            presc_a_d  = bus.cfg_presc;
            period_a_d = bus.cfg_period;
            duty_a_d   = duty_t'(bus.cfg_duty);
            pend_d     = 1'b0;
        end else if (bus.cfg_load) begin
            presc_s_d  = bus.cfg_presc;
            period_s_d = bus.cfg_period;
            duty_s_d   = duty_t'(bus.cfg_duty);
            pend_d     = 1'b1;
        end else if (tick && pend_q) begin
            presc_a_d  = presc_s_q;
            period_a_d = period_s_q;
            duty_a_d   = duty_s_q;
            pend_d     = 1'b0;
        end

        // duty 0 never matches (always low). duty > period always matches (always high).
        for (int i = 0; i < CH; i++) begin
            pwm_d[i] = bus.en && (cnt_q < duty_a_q[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_a_q  <= PRESC_INIT;
            presc_s_q  <= PRESC_INIT;
            period_a_q <= PERIOD_INIT;
            period_s_q <= PERIOD_INIT;
            duty_a_q   <= '0;
            duty_s_q   <= '0;
            pend_q     <= 1'b0;
            pc_q       <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
        end else begin
            presc_a_q  <= presc_a_d;
            presc_s_q  <= presc_s_d;
            period_a_q <= period_a_d;
            period_s_q <= period_s_d;
            duty_a_q   <= duty_a_d;
            duty_s_q   <= duty_s_d;
            pend_q     <= pend_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
        end
    end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: scenario tasks plus randomized traffic, checked against a time-based reference model.
// Latency: the model predicts pwm one cycle after the elapsed-time position it is derived from.
// Backpressure: n/a.
module tb_pwm_multi_gen;
    localparam int CH = 4;
    localparam int CW = 8;
    localparam int PW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_multi_gen_if #(.CH(CH), .CW(CW), .PW(PW)) bus ();

    pwm_multi_gen #(
        .CH(CH), .CW(CW), .PW(PW), .PRESC_RST(39), .PERIOD_RST(0)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model. It tracks the elapsed clk cycles m_t inside the current period.
    // Period length is (presc+1)*(period+1), and the step index is m_t/(presc+1).
    int            m_presc, m_period, s_presc, s_period, m_t;
    int            m_duty [CH];
    int            s_duty [CH];
    bit            m_pend;
    logic [CH-1:0] m_pwm;
    logic          exp_tick;

    assign exp_tick = rst_n && bus.en && (m_t == (m_presc + 1) * (m_period + 1) - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_presc  <= 39;  s_presc  <= 39;
            m_period <= 0;   s_period <= 0;
            m_t      <= 0;
            m_pend   <= 1'b0;
            m_pwm    <= '0;
            for (int i = 0; i < CH; i++) begin
                m_duty[i] <= 0;
                s_duty[i] <= 0;
            end
        end else begin
            for (int i = 0; i < CH; i++)
                m_pwm[i] <= bus.en && ((m_t / (m_presc + 1)) < m_duty[i]);
            if (bus.cfg_load && (!bus.en || exp_tick)) begin
                m_presc  <= int'(bus.cfg_presc);
                m_period <= int'(bus.cfg_period);
                for (int i = 0; i < CH; i++) m_duty[i] <= int'(bus.cfg_duty[i*CW +: CW]);
                if (bus.en) m_pend <= 1'b0;
            end else if (bus.cfg_load) begin
                s_presc  <= int'(bus.cfg_presc);
                s_period <= int'(bus.cfg_period);
                for (int i = 0; i < CH; i++) s_duty[i] <= int'(bus.cfg_duty[i*CW +: CW]);
                m_pend   <= 1'b1;
            end else if (exp_tick && m_pend) begin
                m_presc  <= s_presc;
                m_period <= s_period;
                for (int i = 0; i < CH; i++) m_duty[i] <= s_duty[i];
                m_pend   <= 1'b0;
            end
            m_t <= (!bus.en || exp_tick) ? 0 : m_t + 1;
        end
    end

    task automatic set_cfg(input int presc, input int period,
                           input int d0, input int d1, input int d2, input int d3);
        bus.cfg_presc  = PW'(presc);
        bus.cfg_period = CW'(period);
        bus.cfg_duty   = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
    endtask

    task automatic test_reset;
        int last = -1;
        int ntk  = 0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.cfg_load = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        nchk++; if (bus.pwm !== 4'b0) begin nerr++; $display("FAIL rst_pwm got=%b want=0000", bus.pwm); end
        nchk++; if (bus.period_tick !== 1'b0) begin nerr++; $display("FAIL rst_tick got=%b want=0", bus.period_tick); end
        nchk++; if (bus.cfg_pending !== 1'b0) begin nerr++; $display("FAIL rst_pend got=%b want=0", bus.cfg_pending); end
        @(posedge clk); #1; rst_n = 1'b1; bus.en = 1'b1;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            nchk++;
            if (bus.pwm !== m_pwm || bus.period_tick !== exp_tick || bus.cfg_pending !== m_pend) begin
                nerr++;
                $display("FAIL reset_run c=%0d pwm=%b/%b tick=%b/%b pend=%b/%b", c,
                         bus.pwm, m_pwm, bus.period_tick, exp_tick, bus.cfg_pending, m_pend);
            end
            if (bus.period_tick) begin
                if (last >= 0) begin
                    nchk++;
                    if (c - last != 40) begin nerr++; $display("FAIL reset_interval got=%0d want=40", c - last); end
                end
                last = c; ntk++;
            end
        end
        nchk++; if (ntk != 3) begin nerr++; $display("FAIL reset_tick_count got=%0d want=3", ntk); end
    endtask

    task automatic test_basic_duty;
        int last = -1;
        int ntk  = 0;
        int hi [CH];
        int want [CH] = '{3, 0, 10, 10};
        foreach (hi[i]) hi[i] = 0;
        @(posedge clk); #1;
        bus.en = 1'b0; set_cfg(0, 9, 3, 0, 10, 255); bus.cfg_load = 1'b1;
        @(posedge clk); #1;
        bus.cfg_load = 1'b0; bus.en = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            nchk++;
            if (bus.pwm !== m_pwm || bus.period_tick !== exp_tick || bus.cfg_pending !== m_pend) begin
                nerr++;
                $display("FAIL basic_run c=%0d pwm=%b/%b tick=%b/%b pend=%b/%b", c,
                         bus.pwm, m_pwm, bus.period_tick, exp_tick, bus.cfg_pending, m_pend);
            end
            for (int i = 0; i < CH; i++) hi[i] += int'(bus.pwm[i]);
            if (bus.period_tick) begin
                if (last >= 0) begin
                    nchk++;
                    if (c - last != 10) begin nerr++; $display("FAIL basic_interval got=%0d want=10", c - last); end
                    for (int i = 0; i < CH; i++) begin
                        nchk++;
                        if (hi[i] != want[i]) begin
                            nerr++; $display("FAIL basic_high ch%0d got=%0d want=%0d", i, hi[i], want[i]);
                        end
                    end
                end
                foreach (hi[i]) hi[i] = 0;
                last = c; ntk++;
            end
        end
        nchk++; if (ntk != 5) begin nerr++; $display("FAIL basic_tick_count got=%0d want=5", ntk); end
    endtask

    task automatic test_shadow_update;
        int ntk = 0;
        int sc  = 0;
        int hi0 = 0;
        bit chk_clr = 1'b0;
        for (int c = 0; c < 60 && ntk < 3; c++) begin
            @(negedge clk);
            nchk++;
            if (bus.pwm !== m_pwm || bus.period_tick !== exp_tick || bus.cfg_pending !== m_pend) begin
                nerr++;
                $display("FAIL shadow_run c=%0d pwm=%b/%b tick=%b/%b pend=%b/%b", c,
                         bus.pwm, m_pwm, bus.period_tick, exp_tick, bus.cfg_pending, m_pend);
            end
            bus.cfg_load = 1'b0;
            if (chk_clr) begin
                chk_clr = 1'b0;
                nchk++; if (bus.cfg_pending !== 1'b0) begin nerr++; $display("FAIL shadow_pend_clear got=%b want=0", bus.cfg_pending); end
            end
            if (ntk == 1) begin
                sc++;
                // sc==5 is the cycle with cnt=4, and the load is captured at the end of that cycle.
                if (sc == 5) begin set_cfg(0, 9, 7, 0, 10, 255); bus.cfg_load = 1'b1; end
                if (sc == 6) begin
                    nchk++; if (bus.cfg_pending !== 1'b1) begin nerr++; $display("FAIL shadow_pend_rise got=%b want=1", bus.cfg_pending); end
                end
            end
            hi0 += int'(bus.pwm[0]);
            if (bus.period_tick) begin
                if (ntk == 1) begin
                    nchk++; if (hi0 != 3) begin nerr++; $display("FAIL shadow_old_period got=%0d want=3", hi0); end
                    nchk++; if (bus.cfg_pending !== 1'b1) begin nerr++; $display("FAIL shadow_pend_at_tick got=%b want=1", bus.cfg_pending); end
                    chk_clr = 1'b1;
                end else if (ntk == 2) begin
                    nchk++; if (hi0 != 7) begin nerr++; $display("FAIL shadow_new_period got=%0d want=7", hi0); end
                end
                hi0 = 0; ntk++;
            end
        end
        nchk++; if (ntk != 3) begin nerr++; $display("FAIL shadow_tick_count got=%0d want=3", ntk); end
    endtask

    task automatic test_same_cycle_load;
        int ntk  = 0;
        int last = -1;
        bit rose = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            nchk++;
            if (bus.pwm !== m_pwm || bus.period_tick !== exp_tick || bus.cfg_pending !== m_pend) begin
                nerr++;
                $display("FAIL same_run c=%0d pwm=%b/%b tick=%b/%b pend=%b/%b", c,
                         bus.pwm, m_pwm, bus.period_tick, exp_tick, bus.cfg_pending, m_pend);
            end
            bus.cfg_load = 1'b0;
            if (bus.cfg_pending) rose = 1'b1;
            if (bus.period_tick) begin
                if (ntk == 0) begin
                    set_cfg(0, 4, 2, 5, 0, 1);
                    bus.cfg_load = 1'b1;
                end else if (ntk <= 3) begin
                    nchk++;
                    if (c - last != 5) begin nerr++; $display("FAIL same_interval got=%0d want=5", c - last); end
                end
                last = c; ntk++;
            end
        end
        nchk++; if (rose) begin nerr++; $display("FAIL same_pend_rose got=1 want=0"); end
        nchk++; if (ntk < 4) begin nerr++; $display("FAIL same_tick_count got=%0d want>=4", ntk); end
    endtask

    task automatic test_presc_enable;
        int last = -1;
        int ntk  = 0;
        int hi [CH];
        int want [CH] = '{0, 8, 4, 8};
        foreach (hi[i]) hi[i] = 0;
        @(posedge clk); #1;
        bus.en = 1'b0; set_cfg(3, 1, 0, 5, 1, 2); bus.cfg_load = 1'b1;
        @(posedge clk); #1;
        bus.cfg_load = 1'b0; bus.en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            nchk++;
            if (bus.pwm !== m_pwm || bus.period_tick !== exp_tick || bus.cfg_pending !== m_pend) begin
                nerr++;
                $display("FAIL presc_run c=%0d pwm=%b/%b tick=%b/%b pend=%b/%b", c,
                         bus.pwm, m_pwm, bus.period_tick, exp_tick, bus.cfg_pending, m_pend);
            end
            for (int i = 0; i < CH; i++) hi[i] += int'(bus.pwm[i]);
            if (bus.period_tick) begin
                if (last >= 0) begin
                    nchk++;
                    if (c - last != 8) begin nerr++; $display("FAIL presc_interval got=%0d want=8", c - last); end
                    for (int i = 0; i < CH; i++) begin
                        nchk++;
                        if (hi[i] != want[i]) begin
                            nerr++; $display("FAIL presc_high ch%0d got=%0d want=%0d", i, hi[i], want[i]);
                        end
                    end
                end
                foreach (hi[i]) hi[i] = 0;
                last = c; ntk++;
            end
        end
        // Park a shadow mid-period, then drop en. The shadow must survive until en returns.
        repeat (2) @(negedge clk);
        set_cfg(3, 1, 2, 2, 2, 2); bus.cfg_load = 1'b1;
        @(negedge clk); bus.cfg_load = 1'b0;
        nchk++; if (bus.cfg_pending !== 1'b1) begin nerr++; $display("FAIL en_pend_rise got=%b want=1", bus.cfg_pending); end
        bus.en = 1'b0;
        @(negedge clk);
        nchk++; if (bus.pwm !== 4'b0) begin nerr++; $display("FAIL en_off_pwm got=%b want=0000", bus.pwm); end
        ntk = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.period_tick) ntk++;
            nchk++;
            if (bus.pwm !== 4'b0 || bus.cfg_pending !== 1'b1) begin
                nerr++; $display("FAIL en_off_hold c=%0d pwm=%b want=0000 pend=%b want=1", c, bus.pwm, bus.cfg_pending);
            end
        end
        nchk++; if (ntk != 0) begin nerr++; $display("FAIL en_off_ticks got=%0d want=0", ntk); end
        bus.en = 1'b1;
        ntk = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            nchk++;
            if (bus.pwm !== m_pwm || bus.period_tick !== exp_tick || bus.cfg_pending !== m_pend) begin
                nerr++;
                $display("FAIL en_back_run c=%0d pwm=%b/%b tick=%b/%b pend=%b/%b", c,
                         bus.pwm, m_pwm, bus.period_tick, exp_tick, bus.cfg_pending, m_pend);
            end
            if (bus.period_tick) ntk++;
        end
        nchk++; if (ntk < 3 || bus.cfg_pending !== 1'b0) begin
            nerr++; $display("FAIL en_back_apply ticks=%0d want>=3 pend=%b want=0", ntk, bus.cfg_pending);
        end
        nchk++; if (bus.pwm !== 4'b1111) begin nerr++; $display("FAIL en_back_pwm got=%b want=1111", bus.pwm); end
    endtask

    task automatic test_async_reset;
        int last = -1;
        int ntk  = 0;
        @(negedge clk);
        set_cfg(3, 1, 1, 1, 1, 1); bus.cfg_load = 1'b1;
        @(negedge clk); bus.cfg_load = 1'b0;
        @(posedge clk); #2; rst_n = 1'b0;
        #1;
        nchk++; if (bus.pwm !== 4'b0) begin nerr++; $display("FAIL arst_pwm got=%b want=0000", bus.pwm); end
        nchk++; if (bus.period_tick !== 1'b0) begin nerr++; $display("FAIL arst_tick got=%b want=0", bus.period_tick); end
        nchk++; if (bus.cfg_pending !== 1'b0) begin nerr++; $display("FAIL arst_pend got=%b want=0", bus.cfg_pending); end
        @(posedge clk); #1; rst_n = 1'b1;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            nchk++;
            if (bus.pwm !== m_pwm || bus.period_tick !== exp_tick || bus.cfg_pending !== m_pend) begin
                nerr++;
                $display("FAIL arst_run c=%0d pwm=%b/%b tick=%b/%b pend=%b/%b", c,
                         bus.pwm, m_pwm, bus.period_tick, exp_tick, bus.cfg_pending, m_pend);
            end
            if (bus.period_tick) begin
                if (last >= 0) begin
                    nchk++;
                    if (c - last != 40) begin nerr++; $display("FAIL arst_interval got=%0d want=40", c - last); end
                end
                last = c; ntk++;
            end
        end
        nchk++; if (ntk != 2) begin nerr++; $display("FAIL arst_tick_count got=%0d want=2", ntk); end
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            nchk++;
            if (bus.pwm !== m_pwm || bus.period_tick !== exp_tick || bus.cfg_pending !== m_pend) begin
                nerr++;
                $display("FAIL random_run c=%0d pwm=%b/%b tick=%b/%b pend=%b/%b", c,
                         bus.pwm, m_pwm, bus.period_tick, exp_tick, bus.cfg_pending, m_pend);
            end
            bus.cfg_load = 1'b0;
            if ($urandom_range(0, 19) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 7) == 0) begin
                set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                        int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
                bus.cfg_load = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_shadow_update();
        test_same_cycle_load();
        test_presc_enable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/pwm_multi_gen.md
# pwm_multi_gen

Parametrised multi-channel PWM generator: the programmable successor to the fixed divide-by-40 PWM tick. A prescaler divides `clk`, and a shared period counter drives CH independent duty comparators. Period, prescale and per-channel duty are double-buffered: new values take effect only at a period boundary, so no output ever produces a glitched or truncated pulse. It sits between the register/control logic and the motor/LED output pins.

## Interface
- CH, default 4: number of PWM channels.
- CW, default 8: width of the period counter and of each duty value.
- PW, default 6: width of the prescaler.
- PRESC_RST, default 39: prescale value after reset. The step divider is PRESC+1.
- PERIOD_RST, default 0: period value after reset.

- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable. When 0, counters are held at 0 and outputs are low.
- cfg_load  in  1  one-cycle strobe; captures cfg_presc, cfg_period and cfg_duty.
- cfg_presc  in  PW  prescale value. The step fires every PRESC+1 clk cycles.
- cfg_period  in  CW  period value. The PWM period is PERIOD+1 steps.
- cfg_duty  in  CH*CW  packed duty values; channel i is bits [i*CW +: CW].
- pwm  out  CH  registered PWM outputs.
- period_tick  out  1  one-cycle pulse on period wrap (combinational from registers).
- cfg_pending  out  1  high while shadow values wait for a boundary.

## Operation
- **Register sets.**
  - Active set: presc_a, period_a, duty_a[CH].
  - Shadow set: presc_s, period_s, duty_s[CH].
- **Prescaler `pc`.**
  - While en=1, `pc` counts 0..presc_a and wraps to 0.
  - `step` = en && (pc == presc_a).
- **Period counter `cnt`.**
  - Advances on `step` and wraps from period_a to 0.
  - `period_tick` = step && (cnt == period_a).
- **Outputs.** Each clk: pwm[i] <= en && (cnt < duty_a[i]).
  - Comparison is unsigned at CW bits.
  - duty = 0 gives a constant low output.
  - duty > period_a gives a constant high output.
- **Enable low.** When en=0:
  - pc and cnt are forced to 0.
  - period_tick is 0.
  - pwm <= 0 on the next edge.
- **Configuration load.** The three cases below are mutually exclusive, in priority order.
  1. cfg_load=1 while en=0: cfg_* is written straight into the active set; cfg_pending stays 0.
  2. cfg_load=1 while en=1 and period_tick=1 in the same cycle: cfg_* is written straight into the active set, pc and cnt wrap to 0, and cfg_pending <= 0.
  3. cfg_load=1 while en=1 and period_tick=0: cfg_* is written into the shadow set and cfg_pending <= 1.
     - A second load before the boundary overwrites the shadow; the last one wins.
- **Boundary transfer.** When period_tick=1, cfg_load=0 and cfg_pending=1, the shadow set is copied to the active set and cfg_pending <= 0.
  - The next period runs entirely on the new values, starting at pc=0, cnt=0.
- **Reset (rst=0, asynchronous, any time).**
  - pc=0, cnt=0, pwm=0, cfg_pending=0.
  - presc_a = presc_s = PRESC_RST.
  - period_a = period_s = PERIOD_RST.
  - duty_a = duty_s = 0.
  - period_tick is 0 while in reset.

## Timing
- Step interval: exactly presc_a+1 clk cycles. With PRESC_RST=39 and PERIOD_RST=0, period_tick pulses every 40 cycles, matching the legacy tick.
- PWM period: (presc_a+1)*(period_a+1) clk cycles.
- High time per period: min(duty, period_a+1)*(presc_a+1) cycles.
- pwm lags the cnt value it compares by 1 cycle.
- After en rises, the first pwm high appears 1 cycle later if duty>0. The first period_tick comes (presc_a+1)*(period_a+1) cycles after en rises.
- cfg_pending rises the cycle after cfg_load. It falls the cycle after the period_tick that performs the transfer.
- If en falls mid-period, pending shadow values are retained. They are applied at the first period_tick after en returns.

## Test plan
- **Reset defaults:** hold rst=0, release, en=1 -> period_tick pulses every 40 cycles; pwm=0; cfg_pending=0.
- **Basic duty:** en=0, load presc=0, period=9, duty0=3, duty1=0, duty2=10, duty3=255, then en=1 -> each 10-cycle period has pwm[0] high for 3 cycles, pwm[1] always low, pwm[2] and pwm[3] always high; period_tick every 10 cycles.
- **Shadow update:** while running the basic setup, load duty0=7 at cnt=4 -> cfg_pending=1; the current period still shows 3 high cycles; the next period shows 7; cfg_pending clears after the tick.
- **Same-cycle load at boundary:** assert cfg_load coincident with period_tick, with period=4 -> cfg_pending never rises; the next period_tick arrives 5 cycles later.
- **Prescale with enable/reset:** presc=3, period=1 -> period_tick every 8 cycles. Drop en mid-period -> pwm=0 next cycle and no ticks. Assert rst=0 mid-period -> all outputs 0 immediately and registers return to defaults.
